// File: rtl/reg_bank.sv
// reg_bank: NREGS x WIDTH register bank, one write port, two combinational read ports; top register optionally acts as an incrementing PC with sticky wrap flag
module reg_bank #(
  parameter int WIDTH = 9,
  parameter int NREGS = 8,
  parameter int PC_EN = 1
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  output logic [WIDTH-1:0]         rd_data_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_b,
  input  logic                     pc_incr,
  output logic [WIDTH-1:0]         pc_out,
  output logic                     pc_wrap,
  input  logic                     wrap_clr
);
  localparam int AW = $clog2(NREGS);
  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic wrap_q, wrap_d, pc_we, inc;
  // a write to the PC register takes precedence and suppresses the increment
  assign pc_we = wr_en && (wr_addr == AW'(NREGS-1));
  assign inc = (PC_EN != 0) && pc_incr && !pc_we;
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++)
      if (wr_en && wr_addr == AW'(i)) regs_d[i] = wr_data;
    if (inc) regs_d[NREGS-1] = regs_q[NREGS-1] + WIDTH'(1);
    wrap_d = (inc && &regs_q[NREGS-1]) ? 1'b1 : wrap_clr ? 1'b0 : wrap_q;
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      regs_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr_a == AW'(i)) rd_data_a = regs_q[i];
      if (rd_addr_b == AW'(i)) rd_data_b = regs_q[i];
    end
  end
  assign pc_out = regs_q[NREGS-1];
  assign pc_wrap = wrap_q;
endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank for the processor datapath: replaces the single hard-wired 9-bit register with NREGS general registers of WIDTH bits. It provides one synchronous write port and two combinational read ports. The top register (index NREGS-1) optionally doubles as the program counter, with an increment mode and a sticky wrap flag. It sits between the control FSM and the datapath bus, and feeds the address/instruction path via pc_out.

## Interface
- WIDTH, 9: data width of every register.
- NREGS, 8: number of registers, 2..16. Address width AW = clog2(NREGS), derived locally.
- PC_EN, 1: 1 makes register NREGS-1 the PC (pc_incr active); 0 makes it an ordinary register, with pc_incr ignored and pc_wrap held 0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  register written when wr_en=1.
- wr_data  in  WIDTH  write data.
- rd_addr_a  in  AW  read port A select.
- rd_data_a  out  WIDTH  contents of register rd_addr_a (combinational).
- rd_addr_b  in  AW  read port B select.
- rd_data_b  out  WIDTH  contents of register rd_addr_b (combinational).
- pc_incr  in  1  increment PC register by 1.
- pc_out  out  WIDTH  current contents of register NREGS-1.
- pc_wrap  out  1  sticky flag: PC incremented from all-ones to 0.
- wrap_clr  in  1  clears pc_wrap.

## Operation
- Storage: NREGS x WIDTH flip-flop registers; no memory inference requirement.
- Reset (Reset=1 at a rising edge): every register goes to 0 and pc_wrap goes to 0. Reset overrides wr_en, pc_incr and wrap_clr in that cycle.
- Write: when wr_en=1 and wr_addr < NREGS, register[wr_addr] <= wr_data at the edge. If wr_addr >= NREGS (non-power-of-2 NREGS), the write is ignored.
- Read: rd_data_a/b = register[addr] from current state; there is no write-through bypass, so a read in the write cycle returns the old value. An out-of-range address reads 0.
- PC increment (PC_EN=1): when pc_incr=1, PC <= PC + 1 modulo 2^WIDTH.
- Simultaneous wr_en to NREGS-1 and pc_incr: the write wins, the increment is dropped, and pc_wrap is not affected.
- pc_wrap set condition: an increment is actually applied while PC == all-ones (2^WIDTH-1). Set has priority over wrap_clr in the same cycle; otherwise wrap_clr=1 clears the flag.
- Writes to other registers are independent of pc_incr; both take effect in the same cycle.
- Reset asserted mid-sequence discards any pending write or increment of that cycle; the bank resumes from all-zero state on the first edge with Reset=0.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible on rd_data_a/b and pc_out immediately after edge N.
- Read latency: 0 cycles (combinational mux from registers).
- pc_out is a direct register output with no combinational path from inputs.
- pc_wrap updates at the same edge as the wrapping increment.
- All outputs are 0 after reset: rd_data_a, rd_data_b, pc_out, pc_wrap.
- Back-to-back writes to the same address on consecutive cycles are allowed; the last one wins.
- Back-to-back pc_incr on every cycle advances the PC by 1 per cycle.

## Test plan
- Reset then readback: assert Reset 2 cycles. Then all 8 addresses on both ports read 0, and pc_out=0, pc_wrap=0.
- Write/read: write 9'h1A5 to R3 and 9'h0FF to R5 on consecutive cycles; read A=R3, B=R5. Expect 1A5 and 0FF. In the write cycle itself, R3 read returns the old value 0.
- PC increment and wrap: write R7=9'h1FE, then pc_incr for 3 cycles. Expect pc_out = 1FF, then 000 with pc_wrap=1, then 001 with pc_wrap staying 1. wrap_clr for one cycle then gives pc_wrap=0.
- Write/increment collision: with R7=9'h010, assert wr_en to R7 with data 9'h040 together with pc_incr. Expect pc_out=040 next cycle, not 011.
- Reset mid-operation: with R2=9'h077 and pc_out=9'h1FF, assert Reset together with wr_en and pc_incr. Expect all registers 0 and pc_wrap=0.
- Parameter sweep: WIDTH=16, NREGS=6, PC_EN=1. A write to address 7 is ignored, a read of address 6 returns 0, and the PC (R5) wraps from FFFF to 0000 with pc_wrap=1.
